// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared types and constants for the IF fetch unit
package if_fetch_unit_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - pipeline control, imem bus and IF/ID output bundle
interface if_fetch_unit_if;

   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        valid;
   logic [31:0] inst;
   logic [31:0] pc_plus_4;

   modport master (
      input  stall, redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, valid, inst, pc_plus_4
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, valid, inst, pc_plus_4
   );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// rtl/if_fetch_unit_fifo.sv - 2-entry {inst, pc4} buffer between imem and IF/ID
module fetch_fifo
   import if_fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output fetch_entry_t rdata,
   output logic [1:0]   count
);

   fetch_entry_t mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign rdata   = mem[rd_ptr];

   // pointer and occupancy bookkeeping; flush empties without touching storage
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // entry storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC ownership, imem fetch, stall buffering, redirect
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] NOP_INST = DEF_NOP_INST
)
(
   input logic           clk,
   input logic           reset,
   if_fetch_unit_if.master bus
);

   logic [31:0]  pc;
   logic [31:0]  tag_pc4;
   logic         outstanding;
   logic [0:0]   state;

   logic [1:0]   fifo_count;
   fetch_entry_t fifo_head;
   fetch_entry_t fifo_wdata;
   logic         fifo_empty;
   logic         rsp_hit;
   logic         push;
   logic         pop;
   logic [2:0]   committed;
   logic         req;
   logic         accept;

   // a response only counts when a request is actually in flight
   assign rsp_hit    = bus.imem_rvalid && outstanding;
   assign push       = rsp_hit && (state == ST_RUN) && !bus.redirect;
   assign fifo_empty = (fifo_count == 2'd0);
   assign pop        = !fifo_empty && !bus.stall;
   assign fifo_wdata = '{inst: bus.imem_rdata, pc4: tag_pc4};

   // slots already spoken for after this cycle: buffered minus leaving plus in flight
   assign committed  = {1'b0, fifo_count} + {2'b00, outstanding} - {2'b00, pop};
   assign req        = !reset && !bus.redirect && (state == ST_RUN)
                       && (!outstanding || bus.imem_rvalid) && (committed < 3'd2);
   assign accept     = req && bus.imem_ready;

   assign bus.imem_req  = req;
   assign bus.imem_addr = pc;
   assign bus.valid     = !reset && !fifo_empty;
   assign bus.inst      = bus.valid ? fifo_head.inst : NOP_INST;
   assign bus.pc_plus_4 = bus.valid ? fifo_head.pc4  : 32'h0000_0000;

   fetch_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect),
      .wdata (fifo_wdata),
      .rdata (fifo_head),
      .count (fifo_count)
   );

   // PC, response tag and in-flight flag; redirect wins over sequential advance
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         tag_pc4     <= 32'h0000_0000;
         outstanding <= 1'b0;
      end else begin
         if (bus.redirect)  pc <= word_align(bus.redirect_pc);
         else if (accept)   pc <= pc + 32'd4;
         if (accept)        tag_pc4 <= pc + 32'd4;
         if (accept)        outstanding <= 1'b1;
         else if (rsp_hit)  outstanding <= 1'b0;
      end
   end

   // DRAIN swallows the one wrong-path response still owed by memory
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:   if (bus.redirect && outstanding && !bus.imem_rvalid) state <= ST_DRAIN;
            ST_DRAIN: if (rsp_hit) state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector and sequence bench for if_fetch_unit
module tb_if_fetch_unit;

   typedef struct {
      logic        st;
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc4;
   } vec_t;

   logic clk;
   logic reset;

   if_fetch_unit_if bus();

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;

   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;
   int          lat;
   logic        inject;
   logic [31:0] exp_pc;

   logic        s_req;
   logic [31:0] s_addr;
   logic        s_valid;
   logic [31:0] s_inst;
   logic [31:0] s_pc4;
   logic        s_rvalid;

   vec_t        tbl [22];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic rdy, input logic req, input logic [31:0] addr,
                               input logic valid, input logic [31:0] pc4);
      vec_t v;
      v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
      v.req = req; v.addr = addr; v.valid = valid; v.pc4 = pc4;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy, output logic acc);
      bus.stall       = st;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.imem_ready  = rdy;
      if (inject) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = 32'hDEAD_BEEF;
      end
      #2;
      s_req    = bus.imem_req;
      s_addr   = bus.imem_addr;
      s_valid  = bus.valid;
      s_inst   = bus.inst;
      s_pc4    = bus.pc_plus_4;
      s_rvalid = bus.imem_rvalid;
      acc      = s_req && rdy;
      if (reset) begin
         exp_pc = 32'h0000_0000;
      end else if (rd) begin
         exp_pc = rpc & ~32'h3;
      end else if (s_valid && !st) begin
         check("sb_pc4", s_pc4, exp_pc + 32'd4);
         check("sb_inst", s_inst, inst_of(exp_pc));
         exp_pc = exp_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      if (reset) begin
         pend = 1'b0;
      end else begin
         if (pend && pend_cnt == 0) pend = 1'b0;
         if (acc) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_cnt  = lat - 1;
         end else if (pend && pend_cnt > 0) begin
            pend_cnt--;
         end
      end
      inject          = 1'b0;
      bus.imem_rvalid = pend && (pend_cnt == 0);
      bus.imem_rdata  = bus.imem_rvalid ? inst_of(pend_addr) : 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc;
      logic [31:0] hold_addr;
      int          n;

      tbl[0]  = mk(0, 0, 32'h0,   1, 1, 32'h00,  0, 32'h00);
      tbl[1]  = mk(0, 0, 32'h0,   1, 1, 32'h04,  0, 32'h00);
      tbl[2]  = mk(0, 0, 32'h0,   1, 1, 32'h08,  1, 32'h04);
      tbl[3]  = mk(0, 0, 32'h0,   1, 1, 32'h0C,  1, 32'h08);
      tbl[4]  = mk(1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0C);
      tbl[5]  = mk(1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0C);
      tbl[6]  = mk(1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0C);
      tbl[7]  = mk(1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0C);
      tbl[8]  = mk(1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0C);
      tbl[9]  = mk(0, 0, 32'h0,   1, 1, 32'h10,  1, 32'h0C);
      tbl[10] = mk(0, 0, 32'h0,   1, 1, 32'h14,  1, 32'h10);
      tbl[11] = mk(0, 0, 32'h0,   1, 1, 32'h18,  1, 32'h14);
      tbl[12] = mk(0, 0, 32'h0,   0, 1, 32'h1C,  1, 32'h18);
      tbl[13] = mk(0, 0, 32'h0,   0, 1, 32'h1C,  1, 32'h1C);
      tbl[14] = mk(0, 0, 32'h0,   0, 1, 32'h1C,  0, 32'h00);
      tbl[15] = mk(0, 0, 32'h0,   1, 1, 32'h1C,  0, 32'h00);
      tbl[16] = mk(0, 0, 32'h0,   1, 1, 32'h20,  0, 32'h00);
      tbl[17] = mk(0, 0, 32'h0,   1, 1, 32'h24,  1, 32'h20);
      tbl[18] = mk(0, 1, 32'h200, 1, 0, 32'h28,  1, 32'h24);
      tbl[19] = mk(0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h00);
      tbl[20] = mk(0, 0, 32'h0,   1, 1, 32'h204, 0, 32'h00);
      tbl[21] = mk(0, 0, 32'h0,   1, 1, 32'h208, 1, 32'h204);

      reset           = 1'b1;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0; lat = 1; inject = 1'b0;
      exp_pc = 32'h0;

      step(0, 0, 32'h0, 1, acc);
      step(0, 0, 32'h0, 1, acc);
      check("rst_req", s_req, 1'b0);
      check("rst_valid", s_valid, 1'b0);
      check("rst_inst", s_inst, 32'h0);
      check("rst_pc4", s_pc4, 32'h0);
      check("rst_addr", s_addr, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 22; i++) begin
         step(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, acc);
         check($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
         check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
         check($sformatf("tbl%0d_valid", i), s_valid, tbl[i].valid);
         check($sformatf("tbl%0d_pc4", i), s_pc4, tbl[i].pc4);
      end

      // redirect while a slow fetch is in flight, then a second redirect during DRAIN
      lat = 4;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 10) begin step(0, 0, 32'h0, 1, acc); n++; end
      check("a_accept", acc, 1'b1);
      step(0, 1, 32'h50, 1, acc);
      check("a_redir_req", s_req, 1'b0);
      step(0, 0, 32'h0, 1, acc);
      check("a_flush_valid", s_valid, 1'b0);
      check("a_drain_req", s_req, 1'b0);
      step(0, 1, 32'h0000_0103, 1, acc);
      check("a_redir2_req", s_req, 1'b0);
      n = 0;
      s_rvalid = 1'b0;
      while (!s_rvalid && n < 8) begin
         step(0, 0, 32'h0, 1, acc);
         check("a_drain_req_loop", s_req, 1'b0);
         check("a_drain_valid_loop", s_valid, 1'b0);
         n++;
      end
      check("a_stale_seen", s_rvalid, 1'b1);
      lat = 1;
      step(0, 0, 32'h0, 1, acc);
      check("a_resume_req", s_req, 1'b1);
      check("a_resume_addr", s_addr, 32'h100);
      for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 1, acc);

      // redirect coinciding with a response while stalled: dropped, stays RUN
      acc = 1'b0;
      n = 0;
      while (!acc && n < 10) begin step(0, 0, 32'h0, 1, acc); n++; end
      step(1, 1, 32'h400, 1, acc);
      check("b_rvalid", s_rvalid, 1'b1);
      check("b_redir_req", s_req, 1'b0);
      step(0, 0, 32'h0, 1, acc);
      check("b_valid", s_valid, 1'b0);
      check("b_req", s_req, 1'b1);
      check("b_addr", s_addr, 32'h400);
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 1, acc);

      // memory not ready for 3 cycles, plus an unsolicited rvalid that must be ignored
      step(0, 0, 32'h0, 0, acc);
      hold_addr = s_addr;
      step(0, 0, 32'h0, 0, acc);
      check("c_addr_hold1", s_addr, hold_addr);
      inject = 1'b1;
      step(0, 0, 32'h0, 0, acc);
      check("c_addr_hold2", s_addr, hold_addr);
      check("c_req_hold", s_req, 1'b1);
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 1, acc);

      // PC wraps from the top of the address space
      step(0, 1, 32'hFFFF_FFF8, 1, acc);
      step(0, 0, 32'h0, 1, acc);
      check("d_addr_fff8", s_addr, 32'hFFFF_FFF8);
      step(0, 0, 32'h0, 1, acc);
      check("d_addr_fffc", s_addr, 32'hFFFF_FFFC);
      step(0, 0, 32'h0, 1, acc);
      check("d_addr_wrap", s_addr, 32'h0000_0000);
      for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, acc);

      // reset while draining a wrong-path fetch
      lat = 4;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 10) begin step(0, 0, 32'h0, 1, acc); n++; end
      step(0, 1, 32'h300, 1, acc);
      reset = 1'b1;
      step(0, 0, 32'h0, 1, acc);
      check("e_rst_req", s_req, 1'b0);
      check("e_rst_valid", s_valid, 1'b0);
      reset = 1'b0;
      lat = 1;
      step(0, 0, 32'h0, 1, acc);
      check("e_req", s_req, 1'b1);
      check("e_addr", s_addr, 32'h0);
      check("e_valid", s_valid, 1'b0);
      for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 1, acc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
